unary_add_nch: RTL

Parametrised unary (stochastic/thermometer) bitstream adder. It accepts N_IN serial unary operand streams in parallel and accumulates the number of 1s across all streams into a saturating count. On command, it replays the sum as a unary frame of fixed length MAX_LEN on a single serial output. It sits in the unary arithmetic datapath as the generalised successor of the fixed two-operand, 16-length adder, and adds N-operand input, saturation, frame handshake and synchronous clear.

---
 rtl/unary_add_pkg.sv | 15 +
 rtl/unary_popcount.sv | 18 +
 rtl/unary_add_nch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/unary_add_pkg.sv
// rtl/unary_add_pkg.sv - shared types and parameter checks for the unary N-channel adder
package unary_add_pkg;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The accumulator must be able to hold MAX_LEN itself, the saturation ceiling.
  function automatic bit cnt_w_ok(input int cnt_w, input int max_len);
    return ((longint'(1) << cnt_w) - longint'(1)) >= longint'(max_len);
  endfunction

endpackage

// File: rtl/unary_popcount.sv
// rtl/unary_popcount.sv - combinational count of set bits across the operand streams
module unary_popcount #(
  parameter int N_IN = 2,
  parameter int PC_W = $clog2(N_IN + 1)
) (
  input  logic [N_IN-1:0] bits,
  output logic [PC_W-1:0] count
);

  // Ripple sum of single bits; N_IN is small in practice.
  always_comb begin
    count = '0;
    for (int i = 0; i < N_IN; i++) begin
      count = count + PC_W'(bits[i]);
    end
  end

endmodule

// File: rtl/unary_add_nch.sv
// rtl/unary_add_nch.sv - N-operand saturating unary adder with framed unary replay
module unary_add_nch
  import unary_add_pkg::*;
#(
  parameter int N_IN    = 2,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            read_or_write,
  input  logic            clear,
  input  logic [N_IN-1:0] din,
  output logic            dout,
  output logic            C,
  output logic            busy,
  output logic            done
);

  localparam int  PC_W     = $clog2(N_IN + 1);
  localparam int  K_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int  SUM_W    = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam bit  CNT_W_OK = cnt_w_ok(CNT_W, MAX_LEN);

  localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] MAX_ACC = CNT_W'(MAX_LEN);
  localparam logic [K_W-1:0]   K_LAST  = K_W'(MAX_LEN - 1);

  if (!CNT_W_OK) begin : g_bad_cnt_w
    $error("unary_add_nch: CNT_W too narrow to hold MAX_LEN");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] acc;
  logic [K_W-1:0]   k;
  logic [PC_W-1:0]  pop;
  logic [SUM_W-1:0] sum;
  logic             over;

  unary_popcount #(
    .N_IN (N_IN),
    .PC_W (PC_W)
  ) u_popcount (
    .bits  (din),
    .count (pop)
  );

  // Sum is widened by one bit so overflow past MAX_LEN is visible before clamping.
  assign sum  = SUM_W'(acc) + SUM_W'(pop);
  assign over = (sum > MAX_SUM);

  assign busy = (state == ST_EMIT);
  assign done = (state == ST_DONE);

  // Next state: clear wins, en=0 holds, EMIT ignores the mode input so frames always finish.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_ACC;
    end else if (en) begin
      case (state)
        ST_ACC:  if (read_or_write)  state_nxt = ST_EMIT;
        ST_EMIT: if (k == K_LAST)    state_nxt = ST_DONE;
        ST_DONE: if (!read_or_write) state_nxt = ST_ACC;
        default:                     state_nxt = ST_ACC;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Accumulator, frame counter, overflow flag and serial output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      k    <= '0;
      C    <= 1'b0;
      dout <= 1'b0;
    end else if (clear) begin
      acc  <= '0;
      k    <= '0;
      C    <= 1'b0;
      dout <= 1'b0;
    end else if (en) begin
      case (state)
        ST_ACC: begin
          if (read_or_write) begin
            k <= '0;
          end else begin
            acc <= over ? MAX_ACC : sum[CNT_W-1:0];
            C   <= C | over;
          end
        end
        ST_EMIT: begin
          dout <= (SUM_W'(k) < SUM_W'(acc));
          k    <= k + 1'b1;
        end
        ST_DONE: begin
          dout <= 1'b0;
          if (!read_or_write) begin
            acc <= '0;
            C   <= 1'b0;
          end
        end
        default: begin
          dout <= 1'b0;
        end
      endcase
    end
  end

endmodule
